sap1_datapath: RTL and testbench

SAP1_DATAPATH -- requirements
Module: sap1_datapath

---
 rtl/sap1_pkg.sv | 36 +++
 rtl/sap1_ram16x8.sv | 25 ++
 rtl/sap1_datapath.sv | 111 +++++++++++
 tb/tb_sap1_datapath.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: widths, control-word bit positions, opcodes and
// a helper for detecting bus contention.
package sap1_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int CW_W   = 12;

    // Control-word bit positions, most significant first as issued by the controller
    localparam int CW_CP   = 11;
    localparam int CW_EP   = 10;
    localparam int CW_N_LM = 9;
    localparam int CW_N_CE = 8;
    localparam int CW_N_LI = 7;
    localparam int CW_N_EI = 6;
    localparam int CW_N_LA = 5;
    localparam int CW_EA   = 4;
    localparam int CW_SU   = 3;
    localparam int CW_EU   = 2;
    localparam int CW_N_LB = 1;
    localparam int CW_N_LO = 0;

    localparam logic [3:0] LDA = 4'h1;
    localparam logic [3:0] ADD = 4'h2;
    localparam logic [3:0] SUB = 4'h3;
    localparam logic [3:0] OUT = 4'hE;
    localparam logic [3:0] HLT = 4'hF;

    localparam int NUM_DRIVERS = 5;

    // True when two or more bits of the driver-enable vector are set
    function automatic logic multi_driver(input logic [NUM_DRIVERS-1:0] en);
        return (en & (en - NUM_DRIVERS'(1))) != '0;
    endfunction

endpackage

// File: rtl/sap1_ram16x8.sv
// 16x8 program/data memory: synchronous write port, combinational read port.
module sap1_ram16x8
    import sap1_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    // No reset: contents must survive a datapath reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // A read of the word being written this cycle sees the pre-edge contents
    assign rdata = mem[raddr];

endmodule

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: W-bus multiplexer, PC, MAR, IR, A, B, OUT, carry and ALU,
// with the program RAM as a sub-module.
module sap1_datapath
    import sap1_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              cp,
    input  logic              ep,
    input  logic              ea,
    input  logic              su,
    input  logic              eu,
    input  logic              n_lm,
    input  logic              n_ce,
    input  logic              n_li,
    input  logic              n_ei,
    input  logic              n_la,
    input  logic              n_lb,
    input  logic              n_lo,
    output logic [3:0]        instruction,
    output logic [DATA_W-1:0] out_reg,
    output logic              carry,
    output logic [DATA_W-1:0] bus,
    output logic              bus_err,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data
);

    logic [ADDR_W-1:0]      pc_reg;
    logic [ADDR_W-1:0]      mar_reg;
    logic [DATA_W-1:0]      ir_reg;
    logic [DATA_W-1:0]      a_reg;
    logic [DATA_W-1:0]      b_reg;
    logic [DATA_W-1:0]      ram_data;
    logic [DATA_W-1:0]      b_operand;
    logic [DATA_W:0]        alu_sum;
    logic [NUM_DRIVERS-1:0] drv_en;

    sap1_ram16x8 u_ram (
        .clk   (clk),
        .we    (prog_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (mar_reg),
        .rdata (ram_data)
    );

    // Subtraction is A + ~B + 1; bit 8 is carry for add, not-borrow for subtract
    assign b_operand = su ? ~b_reg : b_reg;
    assign alu_sum   = {1'b0, a_reg} + {1'b0, b_operand} + {{DATA_W{1'b0}}, su};

    assign drv_en = {ep, ~n_ce, ~n_ei, ea, eu};

    always_comb begin
        bus = '0;
        if (ep) begin
            bus = {{(DATA_W - ADDR_W){1'b0}}, pc_reg};
        end else if (!n_ce) begin
            bus = ram_data;
        end else if (!n_ei) begin
            bus = {{(DATA_W - ADDR_W){1'b0}}, ir_reg[ADDR_W-1:0]};
        end else if (ea) begin
            bus = a_reg;
        end else if (eu) begin
            bus = alu_sum[DATA_W-1:0];
        end
    end

    // Every load samples the pre-edge bus, so a driving register reloads itself
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pc_reg  <= '0;
            mar_reg <= '0;
            ir_reg  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            out_reg <= '0;
            carry   <= 1'b0;
            bus_err <= 1'b0;
        end else begin
            if (cp) begin
                pc_reg <= pc_reg + ADDR_W'(1);
            end
            if (!n_lm) begin
                mar_reg <= bus[ADDR_W-1:0];
            end
            if (!n_li) begin
                ir_reg <= bus;
            end
            if (!n_la) begin
                a_reg <= bus;
            end
            if (!n_la && eu) begin
                carry <= alu_sum[DATA_W];
            end
            if (!n_lb) begin
                b_reg <= bus;
            end
            if (!n_lo) begin
                out_reg <= bus;
            end
            if (multi_driver(drv_en)) begin
                bus_err <= 1'b1;
            end
        end
    end

    assign instruction = ir_reg[DATA_W-1:DATA_W-4];

endmodule

// File: tb/tb_sap1_datapath.sv
// Scenario bench for sap1_datapath: expected values are queued as stimulus is
// applied and popped when the corresponding output is observed.
module tb_sap1_datapath;
    import sap1_pkg::*;

    localparam logic [11:0] K_CP = 12'(1 << CW_CP);
    localparam logic [11:0] K_EP = 12'(1 << CW_EP);
    localparam logic [11:0] K_LM = 12'(1 << CW_N_LM);
    localparam logic [11:0] K_CE = 12'(1 << CW_N_CE);
    localparam logic [11:0] K_LI = 12'(1 << CW_N_LI);
    localparam logic [11:0] K_EI = 12'(1 << CW_N_EI);
    localparam logic [11:0] K_LA = 12'(1 << CW_N_LA);
    localparam logic [11:0] K_EA = 12'(1 << CW_EA);
    localparam logic [11:0] K_SU = 12'(1 << CW_SU);
    localparam logic [11:0] K_EU = 12'(1 << CW_EU);
    localparam logic [11:0] K_LB = 12'(1 << CW_N_LB);
    localparam logic [11:0] K_LO = 12'(1 << CW_N_LO);

    logic       clk = 1'b0;
    logic       n_rst;
    logic       cp, ep, ea, su, eu;
    logic       n_lm, n_ce, n_li, n_ei, n_la, n_lb, n_lo;
    logic [3:0] instruction;
    logic [7:0] out_reg;
    logic       carry;
    logic [7:0] bus;
    logic       bus_err;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp;
    logic [7:0] got;

    sap1_datapath dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .cp          (cp),
        .ep          (ep),
        .ea          (ea),
        .su          (su),
        .eu          (eu),
        .n_lm        (n_lm),
        .n_ce        (n_ce),
        .n_li        (n_li),
        .n_ei        (n_ei),
        .n_la        (n_la),
        .n_lb        (n_lb),
        .n_lo        (n_lo),
        .instruction (instruction),
        .out_reg     (out_reg),
        .carry       (carry),
        .bus         (bus),
        .bus_err     (bus_err),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data)
    );

    always #5 clk = ~clk;

    // Controls change on the falling edge, as the real controller does
    task automatic drive(input logic [11:0] act);
        cp   = act[CW_CP];
        ep   = act[CW_EP];
        ea   = act[CW_EA];
        su   = act[CW_SU];
        eu   = act[CW_EU];
        n_lm = ~act[CW_N_LM];
        n_ce = ~act[CW_N_CE];
        n_li = ~act[CW_N_LI];
        n_ei = ~act[CW_N_EI];
        n_la = ~act[CW_N_LA];
        n_lb = ~act[CW_N_LB];
        n_lo = ~act[CW_N_LO];
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply one control word for one rising edge; v is the bus seen before the edge
    task automatic cycle(input logic [11:0] act, output logic [7:0] v);
        drive(act);
        #1 v = bus;
        tick();
        drive('0);
    endtask

    // Look at the bus with a driver enabled but without clocking
    task automatic peek(input logic [11:0] act, output logic [7:0] v);
        drive(act);
        #1 v = bus;
        drive('0);
    endtask

    task automatic prog(input logic [3:0] addr, input logic [7:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_data = data;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        drive('0);
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        tick();
        prog(4'h0, 8'h1A);
        tick();
        n_rst = 1'b1;
        exp_q.push_back(8'h00); #1 got = bus;
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_bus_idle got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); got = {4'h0, instruction};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_instruction got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); got = out_reg;
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_out_reg got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); got = {6'h0, carry, bus_err};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_flags got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); peek(K_EP, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_pc got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); peek(K_EA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL reset_a got=%h exp=%h", got, exp); end
        prog(4'h1, 8'h2B);
        prog(4'hA, 8'hF0);
        prog(4'hB, 8'h20);
        $display("test_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_fetch();
        exp_q.push_back(8'h00); cycle(K_EP | K_LM, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL fetch_pc_bus got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h1A); cycle(K_CE | K_LI | K_CP, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL fetch_ram0 got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h01); got = {4'h0, instruction};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL fetch_instruction got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h01); peek(K_EP, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL fetch_pc_incr got=%h exp=%h", got, exp); end
        $display("test_fetch done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_add();
        exp_q.push_back(8'h0A); cycle(K_EI | K_LM, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL lda_operand got=%h exp=%h", got, exp); end
        exp_q.push_back(8'hF0); cycle(K_CE | K_LA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL lda_data got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h01); cycle(K_EP | K_LM, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL add_fetch_pc got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h2B); cycle(K_CE | K_LI | K_CP, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL add_fetch_ir got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h02); got = {4'h0, instruction};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL add_instruction got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h0B); cycle(K_EI | K_LM, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL add_operand got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h20); cycle(K_CE | K_LB, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL add_load_b got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h10); cycle(K_EU | K_LA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL add_alu got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h01); got = {7'h0, carry};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL add_carry got=%h exp=%h", got, exp); end
        // Self-reload with eu=0, then ALU drive without a load: carry must hold
        exp_q.push_back(8'h10); cycle(K_EA | K_LA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL self_reload_bus got=%h exp=%h", got, exp); end
        exp_q.push_back(8'hF0); cycle(K_EU | K_SU, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL alu_no_load got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h10); peek(K_EA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL self_reload_a got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h01); got = {7'h0, carry};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL carry_hold got=%h exp=%h", got, exp); end
        $display("test_add done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_sub();
        // MAR=11 holding 8'h20; overwrite it in the same cycle it is read
        prog_we = 1'b1; prog_addr = 4'hB; prog_data = 8'h05;
        exp_q.push_back(8'h20); cycle(K_CE | K_LA, got);
        prog_we = 1'b0;
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_old_data got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h05); cycle(K_CE | K_LA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_new_data got=%h exp=%h", got, exp); end
        prog(4'hB, 8'h07);
        exp_q.push_back(8'h07); cycle(K_CE | K_LB, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL sub_load_b got=%h exp=%h", got, exp); end
        exp_q.push_back(8'hFE); cycle(K_SU | K_EU | K_LA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL sub_alu got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); got = {7'h0, carry};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL sub_carry got=%h exp=%h", got, exp); end
        exp_q.push_back(8'hFE); cycle(K_EA | K_LO, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL sub_a got=%h exp=%h", got, exp); end
        exp_q.push_back(8'hFE); got = out_reg;
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL out_load got=%h exp=%h", got, exp); end
        $display("test_sub done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_pc_wrap();
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        exp_q.push_back(8'h1A); cycle(K_CE | K_LA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_load_a got=%h exp=%h", got, exp); end
        for (int i = 0; i < 15; i++) begin
            cycle(K_CP, got);
        end
        exp_q.push_back(8'h0F); cycle(K_CP | K_EP, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL pc_pre_increment got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); peek(K_EP, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL pc_wrap got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h1A); peek(K_EA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_a_kept got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h1A); peek(K_EU, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_b_kept got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); got = {out_reg[7:1], bus_err} | {4'h0, instruction};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL wrap_others got=%h exp=%h", got, exp); end
        $display("test_pc_wrap done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_conflict();
        exp_q.push_back(8'h00); cycle(K_EP | K_EA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL conflict_bus got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h01); got = {7'h0, bus_err};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bus_err_set got=%h exp=%h", got, exp); end
        for (int i = 0; i < 3; i++) tick();
        exp_q.push_back(8'h01); got = {7'h0, bus_err};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bus_err_sticky got=%h exp=%h", got, exp); end
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        exp_q.push_back(8'h00); got = {7'h0, bus_err};
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL bus_err_clear got=%h exp=%h", got, exp); end
        $display("test_conflict done: checks=%0d errors=%0d", checks, errors);
    endtask

    task automatic test_mid_reset();
        prog(4'h0, 8'h55);
        n_rst = 1'b0;
        exp_q.push_back(8'h55); cycle(K_CE | K_LA, got);
        n_rst = 1'b1;
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mid_reset_bus got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h00); peek(K_EA, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL mid_reset_a got=%h exp=%h", got, exp); end
        exp_q.push_back(8'h55); peek(K_CE, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram_kept got=%h exp=%h", got, exp); end
        prog(4'h0, 8'h1A);
        cycle(K_CE | K_LI, got);
        cycle(K_EI | K_LM, got);
        exp_q.push_back(8'hF0); peek(K_CE, got);
        exp = exp_q.pop_front(); checks++;
        if (got !== exp) begin errors++; $display("FAIL ram10_unchanged got=%h exp=%h", got, exp); end
        $display("test_mid_reset done: checks=%0d errors=%0d", checks, errors);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fetch();
        test_add();
        test_sub();
        test_pc_wrap();
        test_conflict();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
